// File: rtl/fetch_queue.sv
// Prefetching instruction queue: keeps a fetch PC, issues one memory request at a time
// and buffers returned instructions in a DEPTH-entry FIFO drained by the issue stage.
module fetch_queue #(
  parameter int unsigned         DATA_W   = 32,
  parameter int unsigned         ADDR_W   = 32,
  parameter int unsigned         DEPTH    = 8,
  parameter int unsigned         PTR_W    = 3,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0,
  parameter logic [ADDR_W-1:0]   PC_STEP  = ADDR_W'(4)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_redirect,
  input  logic [ADDR_W-1:0] in_redirect_pc,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic              out_mem_rdy,
  input  logic              in_mem_rdy,
  input  logic [DATA_W-1:0] in_mem_instr,
  output logic              out_instr_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_instr_pc,
  input  logic              in_consume,
  output logic [PTR_W:0]    out_count,
  output logic [1:0]        out_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  state_t            state_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [PTR_W:0]    count_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_rdy_q;
  logic [DATA_W-1:0] instr_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q    [DEPTH];

  // Handshakes: out_instr_valid/in_consume pops the head on any rdy edge where both are
  // high (consume while empty is ignored); out_mem_rdy is a one-cycle request and the
  // memory answers with exactly one in_mem_rdy pulse, which must arrive while rdy=1.
  logic pop;
  logic push;
  logic issue;

  assign pop   = in_consume && (count_q != '0);
  assign push  = (state_q == WAIT) && in_mem_rdy;
  // Only issue when a slot is guaranteed free for the response.
  assign issue = (state_q == IDLE) && ((count_q != CNT_FULL) || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      mem_addr_q <= '0;
      mem_rdy_q  <= 1'b0;
    end else begin
      mem_rdy_q <= 1'b0;
      if (rdy) begin
        if (in_redirect) begin
          head_q     <= '0;
          tail_q     <= '0;
          count_q    <= '0;
          fetch_pc_q <= in_redirect_pc;
          // An outstanding request whose response has not yet arrived must be squashed.
          if (state_q == IDLE || in_mem_rdy) begin
            state_q <= IDLE;
          end else begin
            state_q <= DISCARD;
          end
        end else begin
          if (pop) begin
            head_q <= head_q + PTR_ONE;
          end
          if (push) begin
            tail_q     <= tail_q + PTR_ONE;
            fetch_pc_q <= fetch_pc_q + PC_STEP;
          end
          if (push && !pop) begin
            count_q <= count_q + CNT_ONE;
          end else if (pop && !push) begin
            count_q <= count_q - CNT_ONE;
          end
          case (state_q)
            IDLE: begin
              if (issue) begin
                mem_addr_q <= fetch_pc_q;
                mem_rdy_q  <= 1'b1;
                state_q    <= WAIT;
              end
            end
            WAIT, DISCARD: begin
              if (in_mem_rdy) begin
                state_q <= IDLE;
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && !in_redirect && push) begin
      instr_mem_q[tail_q] <= in_mem_instr;
      pc_mem_q[tail_q]    <= fetch_pc_q;
    end
  end

  assign out_mem_addr    = mem_addr_q;
  assign out_mem_rdy     = mem_rdy_q;
  assign out_instr_valid = (count_q != '0);
  assign out_instr       = instr_mem_q[head_q];
  assign out_instr_pc    = pc_mem_q[head_q];
  assign out_count       = count_q;
  assign out_state       = state_q;

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the single-instruction fetcher.
- Keeps its own fetch PC and prefetches sequential instructions from the memory controller into a DEPTH-entry FIFO; downstream decode/dispatch drains one instruction per cycle.
- Supports a redirect (branch/jump/flush) that empties the queue and squashes an in-flight memory response.
- Sits between the memory controller and the issue stage (RS/LSB/ROB dispatch).

Parameters:
- DATA_W, 32, instruction width in bits.
- ADDR_W, 32, PC/address width in bits.
- DEPTH, 8, queue entries; power of two, ≥2.
- PTR_W, 3, log2(DEPTH).
- RESET_PC, 0, fetch PC loaded at reset.
- PC_STEP, 4, PC increment per fetched instruction.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- rdy  in  1  global enable; when low, all state holds.
- in_redirect  in  1  flush queue and restart fetch at in_redirect_pc.
- in_redirect_pc  in  ADDR_W  new fetch PC.
- out_mem_addr  out  ADDR_W  fetch address, held stable after request.
- out_mem_rdy  out  1  one-cycle request pulse to memory.
- in_mem_rdy  in  1  memory response valid (one cycle).
- in_mem_instr  in  DATA_W  returned instruction.
- out_instr_valid  out  1  queue head valid (count != 0).
- out_instr  out  DATA_W  head instruction.
- out_instr_pc  out  ADDR_W  PC of head instruction.
- in_consume  in  1  downstream takes head this cycle.
- out_count  out  PTR_W+1  current occupancy.

Behaviour:
- Reset (rst=1 at clk edge, overrides rdy):
  - fetch_pc=RESET_PC, head=tail=count=0, state=IDLE.
  - out_mem_rdy=0, out_mem_addr=0, out_instr_valid=0, out_count=0.
- out_mem_rdy defaults to 0 every edge and is high for exactly one cycle per request.
- When rdy=0: no state, pointer or PC change; out_mem_rdy=0; a memory response arriving then is lost, so the memory controller must only respond while rdy=1.
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, response will be kept.
  - DISCARD: request outstanding, response will be dropped.
- IDLE → WAIT: when count + (pop this cycle ? -1 : 0) < DEPTH and no redirect. out_mem_addr<=fetch_pc, out_mem_rdy<=1. This reserves a slot so a response can never overflow the queue.
- WAIT + in_mem_rdy: write {fetch_pc, in_mem_instr} at tail; tail+=1 mod DEPTH; fetch_pc+=PC_STEP; go to IDLE. The entry is visible on out_instr* the next cycle. Minimum request-to-request spacing is 2 cycles after the response.
- Pop: when in_consume && out_instr_valid && rdy, head+=1 mod DEPTH. in_consume while empty is ignored.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Redirect (rdy=1) has priority over push, pop and issue in that cycle:
  - head=tail=count=0; fetch_pc=in_redirect_pc.
  - From IDLE: go to IDLE; the new request issues next cycle.
  - From WAIT without in_mem_rdy: go to DISCARD.
  - From WAIT with in_mem_rdy the same cycle: response dropped, go to IDLE.
  - From DISCARD: stay in DISCARD.
- DISCARD + in_mem_rdy: drop data, no PC change, go to IDLE.
- Pointer wrap: PTR_W-bit pointers wrap naturally. Full (count=DEPTH) and empty (count=0) are distinguished by count.
- PC arithmetic: modulo 2^ADDR_W; wrap from all-ones is silent.
- out_instr/out_instr_pc: combinational read of the head entry. Contents are don't-care when invalid.

Test Plan:
- Reset then stream: memory answers 2 cycles after each request with instr = addr^0xFFFF_FFFF, in_consume=1 → out_instr_pc sequence 0,4,8,…; each out_instr matches its PC; no gaps beyond request latency.
- Backpressure: in_consume=0 → exactly 8 requests issued (addr 0..0x1C); out_count saturates at 8; no 9th out_mem_rdy pulse. Pop one → next request for 0x20 on the following cycle.
- Redirect mid-flight: request to 0x10 outstanding, assert in_redirect with pc 0x100 → queue empties (count 0); the 0x10 response is dropped; the next request is to 0x100; first delivered out_instr_pc=0x100.
- Redirect coincident with in_mem_rdy and in_consume → response dropped, no pop effect, count=0, next request to the redirect PC.
- rdy stall: drop rdy for 5 cycles with queue half full and in_consume=1 → out_count, pointers and fetch PC unchanged; no out_mem_rdy pulse; everything resumes identically afterwards.
- Wrap-around: push/pop 20 instructions with random in_consume → FIFO order preserved across pointer wrap. Also check rst asserted mid-WAIT restores fetch_pc=RESET_PC and count=0.
